// File: rtl/axis_downsizer.sv
// axis_downsizer: AXI4-Stream width down-converter.
//
// Holds one wide S_N-byte slave beat and presents it as up to R narrow
// M_N-byte master beats (M_N = S_N/R), least-significant slice first.
// When USE_TKEEP = 1, slices with no keep bits set are skipped. An all-null
// beat with tlast = 1 still produces one empty slice 0 so the packet boundary
// survives. An all-null beat without tlast is consumed silently.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. The master side never drops m_tvalid or changes m_* while
// m_tready is low. s_tready depends combinationally on m_tready, so the next
// wide beat loads in the same cycle as the final slice leaves and no bubble
// appears. m_tvalid is purely registered and has no path from s_tvalid.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   s_t*                wide slave stream (data/keep/strb/last/id/dest/user)
//   m_t*                narrow master stream; id/dest/user held for the beat
//   dbg_state_o         current FSM state (0 = EMPTY, 1 = FULL)
module axis_downsizer #(
  parameter int S_N       = 8,
  parameter int R         = 4,
  parameter int I         = 1,
  parameter int D         = 1,
  parameter int U         = 1,
  parameter int USE_TSTRB = 0,
  parameter int USE_TKEEP = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [8*S_N-1:0]       s_tdata,
  input  logic [S_N-1:0]         s_tkeep,
  input  logic [S_N-1:0]         s_tstrb,
  input  logic                   s_tlast,
  input  logic [I-1:0]           s_tid,
  input  logic [D-1:0]           s_tdest,
  input  logic [U-1:0]           s_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [8*(S_N/R)-1:0]   m_tdata,
  output logic [(S_N/R)-1:0]     m_tkeep,
  output logic [(S_N/R)-1:0]     m_tstrb,
  output logic                   m_tlast,
  output logic [I-1:0]           m_tid,
  output logic [D-1:0]           m_tdest,
  output logic [U-1:0]           m_tuser,
  output logic                   dbg_state_o
);

  localparam int M_N = S_N / R;
  localparam int IW  = $clog2(R);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             load;
  logic [8*S_N-1:0] data_q;
  logic [S_N-1:0]   keep_q, strb_q;
  logic             last_q;
  logic [I-1:0]     id_q;
  logic [D-1:0]     dest_q;
  logic [U-1:0]     user_q;

  // Slice occupancy of the held beat and of the incoming beat.
  logic [R-1:0]  held_nn, in_nn;
  logic [IW-1:0] next_idx, first_idx;
  logic          is_final, in_all_null, drop_in;

  always_comb begin
    held_nn     = '0;
    in_nn       = '0;
    next_idx    = idx_q;
    is_final    = 1'b1;
    first_idx   = '0;
    in_all_null = 1'b1;
    for (int k = 0; k < R; k++) begin
      held_nn[k] = (USE_TKEEP != 0) ? |keep_q[k*M_N +: M_N] : 1'b1;
      in_nn[k]   = (USE_TKEEP != 0) ? |s_tkeep[k*M_N +: M_N] : 1'b1;
    end
    // Descending scan so the lowest qualifying index wins.
    for (int k = R - 1; k >= 0; k--) begin
      if (held_nn[k] && (k > int'(idx_q))) begin
        next_idx = IW'(k);
        is_final = 1'b0;
      end
      if (in_nn[k]) begin
        first_idx   = IW'(k);
        in_all_null = 1'b0;
      end
    end
    // An all-null beat without tlast carries nothing worth emitting.
    drop_in = in_all_null && !s_tlast;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Held beat payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      keep_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
      id_q   <= '0;
      dest_q <= '0;
      user_q <= '0;
    end else if (load) begin
      data_q <= s_tdata;
      keep_q <= s_tkeep;
      strb_q <= s_tstrb;
      last_q <= s_tlast;
      id_q   <= s_tid;
      dest_q <= s_tdest;
      user_q <= s_tuser;
    end
  end

  // Next-state logic. In FULL the slave is only ready on the final slice
  // with m_tready high, so s_tvalid there means the new beat is accepted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (s_tvalid && !drop_in) begin
          state_d = ST_FULL;
          idx_d   = first_idx;
          load    = 1'b1;
        end
      end
      ST_FULL: begin
        if (m_tready) begin
          if (!is_final) begin
            idx_d = next_idx;
          end else if (s_tvalid && !drop_in) begin
            idx_d = first_idx;
            load  = 1'b1;
          end else begin
            state_d = ST_EMPTY;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs. Payload is forced to zero whenever nothing is being offered.
  always_comb begin
    m_tvalid    = (state_q == ST_FULL) && !reset;
    s_tready    = !reset && ((state_q == ST_EMPTY) || (is_final && m_tready));
    dbg_state_o = state_q;
    m_tdata     = '0;
    m_tkeep     = '0;
    m_tstrb     = '0;
    m_tlast     = 1'b0;
    m_tid       = '0;
    m_tdest     = '0;
    m_tuser     = '0;
    if (m_tvalid) begin
      m_tdata = data_q[int'(idx_q)*8*M_N +: 8*M_N];
      m_tkeep = (USE_TKEEP != 0) ? keep_q[int'(idx_q)*M_N +: M_N] : '1;
      m_tstrb = (USE_TSTRB != 0) ? strb_q[int'(idx_q)*M_N +: M_N] : m_tkeep;
      m_tlast = last_q && is_final;
      m_tid   = id_q;
      m_tdest = dest_q;
      m_tuser = user_q;
    end
  end

endmodule
